// File: rtl/ro_meas_pkg.sv
// Shared types and defaults for the ring-oscillator measurement scheduler.
// Holds the FSM state encoding and the select-width helper.
package ro_meas_pkg;

  localparam int DEF_NUM_RO     = 4;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_GATE_LOG2  = 10;
  localparam int DEF_SETTLE_CYC = 8;

  // A single oscillator still needs a 1-bit select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_SEL_W = sel_w(DEF_NUM_RO);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    LATCH  = 2'd3
  } state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchroniser with a registered rising-edge detector for one
// asynchronous oscillator tap.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  // sh[0..1] synchronise; sh[2] holds the previous synchronised value.
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], d};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/ro_meas_sched.sv
// Sweeps NUM_RO ring oscillators: enable, settle, count edges over a fixed
// gate window, then latch the count with a done pulse.
//
// state  | meaning
// IDLE   | waiting for start with ena high
// SETTLE | oscillator enabled, waiting SETTLE_CYC cycles
// GATE   | counting synchronised rising edges for 2^GATE_LOG2 cycles
// LATCH  | one cycle: publish result, pick next oscillator or stop
module ro_meas_sched
  import ro_meas_pkg::*;
#(
  parameter int NUM_RO     = DEF_NUM_RO,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GATE_LOG2  = DEF_GATE_LOG2,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [NUM_RO-1:0]         ro_in,
  output logic                      ro_en,
  output logic [sel_w(NUM_RO)-1:0]  ro_sel,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          result,
  output logic [sel_w(NUM_RO)-1:0]  result_id,
  output logic                      ovf
);

  localparam int SEL_W    = sel_w(NUM_RO);
  localparam int GATE_CYC = 2 ** GATE_LOG2;
  localparam int TMR_W    = ((GATE_LOG2 > $clog2(SETTLE_CYC)) ? GATE_LOG2 : $clog2(SETTLE_CYC)) + 1;

  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_RO - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t            state, state_nx;
  logic [TMR_W-1:0]  tmr, tmr_nx;
  logic [SEL_W-1:0]  sel_nx;
  logic              cnt_clr, latch;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_ovf;
  logic              ro_mux, rise;

  assign ro_mux = ro_in[ro_sel];

  ro_edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ro_mux),
    .rise  (rise)
  );

  assign ro_en = (state == SETTLE) || (state == GATE);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      tmr    <= '0;
      ro_sel <= '0;
    end else begin
      state  <= state_nx;
      tmr    <= tmr_nx;
      ro_sel <= sel_nx;
    end
  end

  // Timer is a down-counter; each phase ends on terminal count zero.
  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    sel_nx   = ro_sel;
    cnt_clr  = 1'b0;
    latch    = 1'b0;
    if (!ena) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = SETTLE;
            sel_nx   = '0;
            tmr_nx   = SETTLE_LD;
          end
        end
        SETTLE: begin
          if (tmr == '0) begin
            state_nx = GATE;
            tmr_nx   = GATE_LD;
            cnt_clr  = 1'b1;
          end else begin
            tmr_nx = tmr - 1'b1;
          end
        end
        GATE: begin
          if (tmr == '0) state_nx = LATCH;
          else           tmr_nx   = tmr - 1'b1;
        end
        LATCH: begin
          latch = 1'b1;
          if (ro_sel != LAST_SEL) begin
            state_nx = SETTLE;
            sel_nx   = ro_sel + 1'b1;
            tmr_nx   = SETTLE_LD;
          end else if (continuous) begin
            state_nx = SETTLE;
            sel_nx   = '0;
            tmr_nx   = SETTLE_LD;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      cnt_ovf   <= 1'b0;
      result    <= '0;
      result_id <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= latch;
      if (latch) begin
        result    <= cnt;
        result_id <= ro_sel;
        ovf       <= cnt_ovf;
      end
      // Saturate rather than wrap so a fast oscillator never reads as slow.
      if (cnt_clr) begin
        cnt     <= '0;
        cnt_ovf <= 1'b0;
      end else if ((state == GATE) && rise) begin
        if (cnt == CNT_MAX) cnt_ovf <= 1'b1;
        else                cnt     <= cnt + 1'b1;
      end
    end
  end

endmodule
